// File: rtl/fpa_pkg.sv
// fpa_pkg: shared state encoding and constants for the FP adder sequencer
package fpa_pkg;
    localparam int FPA_W = 8;
    localparam logic [15:0] DISP_ERR = 16'hEEEE;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, ERR} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and rising-edge press pulse
// Ports: clk, reset (async active-low), btn (raw), level (debounced), press (1-cycle rise pulse)
module btn_debounce #(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            // any sample matching the current level restarts the run
            if (s2 == level) cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= s2;
                press <= s2;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fpa_sequencer.sv
// fpa_sequencer: debounces buttons, launches the FP adder, captures its sum, selects display value
// Ports: clk, reset (async active-low), start_btn/show_btn (raw), sw (A=[15:8], B=[7:0]),
//        fpa_a/fpa_b/fpa_start to adder, fpa_sum/fpa_valid from adder, disp_value, busy, done, error
// Option: FPA_TIMEOUT_EN enables the WAIT timeout counter and the ERR state
module fpa_sequencer
    import fpa_pkg::*;
#(
    parameter int DB_CYCLES      = 100000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_btn,
    input  logic              show_btn,
    input  logic [15:0]       sw,
    output logic [FPA_W-1:0]  fpa_a,
    output logic [FPA_W-1:0]  fpa_b,
    output logic              fpa_start,
    input  logic [FPA_W-1:0]  fpa_sum,
    input  logic              fpa_valid,
    output logic [15:0]       disp_value,
    output logic              busy,
    output logic              done,
    output logic              error
);
    state_t state, next;
    logic start_press, show_db, unused_start_level, unused_show_press;
    logic [FPA_W-1:0] op_a, op_b, result;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start (
        .clk(clk), .reset(reset), .btn(start_btn), .level(unused_start_level), .press(start_press)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_show (
        .clk(clk), .reset(reset), .btn(show_btn), .level(show_db), .press(unused_show_press)
    );

`ifdef FPA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic expired;
    assign expired = tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start_press ? LAUNCH : IDLE;
            LAUNCH:  next = WAIT;
`ifdef FPA_TIMEOUT_EN
            // a valid on the expiry cycle still wins
            WAIT:    next = fpa_valid ? DONE : expired ? ERR : WAIT;
            ERR:     next = start_press ? LAUNCH : ERR;
`else
            WAIT:    next = fpa_valid ? DONE : WAIT;
`endif
            DONE:    next = start_press ? LAUNCH : DONE;
            default: next = IDLE;
        endcase
    end

    // outputs decode the state flops directly, so they carry no input-to-output path
    always_comb begin
        fpa_start = state == LAUNCH;
        busy      = state == LAUNCH || state == WAIT;
        done      = state == DONE;
`ifdef FPA_TIMEOUT_EN
        error     = state == ERR;
`else
        error     = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
`ifdef FPA_TIMEOUT_EN
            tcnt   <= '0;
`endif
        end else begin
            // LAUNCH is only entered from a press in IDLE, DONE or ERR
            if (next == LAUNCH && state != LAUNCH) begin
                op_a <= sw[15:8];
                op_b <= sw[7:0];
            end
            if (state == WAIT && fpa_valid) result <= fpa_sum;
`ifdef FPA_TIMEOUT_EN
            tcnt <= state == LAUNCH ? '0 : state == WAIT ? tcnt + 1'b1 : tcnt;
`endif
        end
    end

    assign fpa_a = op_a;
    assign fpa_b = op_b;
    assign disp_value = show_db && state == ERR  ? DISP_ERR :
                        show_db && state == DONE ? {8'h00, result} : sw;
endmodule

// File: tb/tb_fpa_sequencer.sv
// tb_fpa_sequencer: directed self-checking bench for fpa_sequencer with a behavioural adder
module tb_fpa_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_btn = 1'b0;
    logic        show_btn = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [7:0]  fpa_a, fpa_b, fpa_sum;
    logic        fpa_start, fpa_valid, busy, done, error;
    logic [15:0] disp_value;
    logic        adder_en = 1'b1;
    int          dly = 3;
    logic [15:0] hist = 16'h0000;
    int          n_start = 0;
    int          base = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    fpa_sequencer #(.DB_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .show_btn(show_btn), .sw(sw),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_start(fpa_start), .fpa_sum(fpa_sum),
        .fpa_valid(fpa_valid), .disp_value(disp_value), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // behavioural adder: valid dly cycles after the start pulse
    always @(posedge clk) hist <= {hist[14:0], fpa_start};
    always @(posedge clk) if (fpa_start) n_start <= n_start + 1;
    assign fpa_valid = adder_en && hist[dly-1];
    assign fpa_sum   = 8'h5A;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int i = 0;
        while (fpa_start !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        chk(tag, {15'd0, fpa_start}, 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_error", {15'd0, error}, 16'd0);
        chk("rst_start", {15'd0, fpa_start}, 16'd0);
        chk("rst_ops", {fpa_a, fpa_b}, 16'h0000);
        reset = 1'b1;
        tick(2);
        // reset in the middle of WAIT
        sw = 16'h1234;
        start_btn = 1'b1;
        wait_start("t1_launch");
        tick();
        chk("t1_wait_busy", {15'd0, busy}, 16'd1);
        reset = 1'b0;
        start_btn = 1'b0;
        tick();
        chk("t1_rst_busy", {15'd0, busy}, 16'd0);
        chk("t1_rst_ops", {fpa_a, fpa_b}, 16'h0000);
        chk("t1_rst_start", {15'd0, fpa_start}, 16'd0);
        reset = 1'b1;
        tick(2);
        chk("t1_late_valid_done", {15'd0, done}, 16'd0);
        chk("t1_late_valid_busy", {15'd0, busy}, 16'd0);
        tick(4);
        // normal operation
        sw = 16'h3C41;
        base = n_start;
        start_btn = 1'b1;
        wait_start("t2_launch");
        chk("t2_ops", {fpa_a, fpa_b}, 16'h3C41);
        chk("t2_busy", {15'd0, busy}, 16'd1);
        start_btn = 1'b0;
        tick();
        chk("t2_single_pulse", {15'd0, fpa_start}, 16'd0);
        tick(2);
        chk("t2_valid_cycle_done", {15'd0, done}, 16'd0);
        tick();
        chk("t2_done", {15'd0, done}, 16'd1);
        chk("t2_idle_busy", {15'd0, busy}, 16'd0);
        chk("t2_disp_live", disp_value, 16'h3C41);
        chk("t2_start_count", 16'(n_start - base), 16'd1);
        // display select
        show_btn = 1'b1;
        sw = 16'hFFFF;
        tick(7);
        chk("t3_show_sum", disp_value, 16'h005A);
        show_btn = 1'b0;
        tick(7);
        chk("t3_show_off", disp_value, 16'hFFFF);
        // press dropped while busy, adder never answers
        adder_en = 1'b0;
        sw = 16'h7788;
        base = n_start;
        start_btn = 1'b1;
        tick(4);
        start_btn = 1'b0;
        tick(3);
        chk("t4_launch", {15'd0, fpa_start}, 16'd1);
        chk("t4_ops", {fpa_a, fpa_b}, 16'h7788);
        tick();
        start_btn = 1'b1;
        chk("t4_wait_start", {15'd0, fpa_start}, 16'd0);
        tick(7);
        chk("t4_busy_press_drop", {15'd0, fpa_start}, 16'd0);
        chk("t4_last_wait_busy", {15'd0, busy}, 16'd1);
        chk("t4_last_wait_err", {15'd0, error}, 16'd0);
        start_btn = 1'b0;
        tick();
`ifdef FPA_TIMEOUT_EN
        chk("t4_error", {15'd0, error}, 16'd1);
        chk("t4_err_busy", {15'd0, busy}, 16'd0);
`else
        chk("t4_no_error", {15'd0, error}, 16'd0);
        chk("t4_still_busy", {15'd0, busy}, 16'd1);
`endif
        show_btn = 1'b1;
        tick(7);
`ifdef FPA_TIMEOUT_EN
        chk("t4_disp_err", disp_value, 16'hEEEE);
`else
        chk("t4_disp_live", disp_value, 16'h7788);
        chk("t4_hold_busy", {15'd0, busy}, 16'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
`endif
        chk("t4_start_count", 16'(n_start - base), 16'd1);
        // relaunch after error (or after reset without the timeout)
        adder_en = 1'b1;
        sw = 16'h1122;
        start_btn = 1'b1;
        wait_start("t5_relaunch");
        chk("t5_error_clear", {15'd0, error}, 16'd0);
        chk("t5_ops", {fpa_a, fpa_b}, 16'h1122);
        start_btn = 1'b0;
        tick(4);
        chk("t5_done", {15'd0, done}, 16'd1);
        chk("t5_disp_sum", disp_value, 16'h005A);
        // 2-cycle bounce gives no press
        base = n_start;
        start_btn = 1'b1;
        tick(2);
        start_btn = 1'b0;
        tick(10);
        chk("t6_bounce_count", 16'(n_start - base), 16'd0);
        chk("t6_bounce_done", {15'd0, done}, 16'd1);
        // valid on the timeout-expiry cycle
        dly = 8;
        start_btn = 1'b1;
        wait_start("t7_launch");
        start_btn = 1'b0;
        tick(7);
        chk("t7_pre_busy", {15'd0, busy}, 16'd1);
        chk("t7_pre_done", {15'd0, done}, 16'd0);
        tick();
        chk("t7_expiry_busy", {15'd0, busy}, 16'd1);
        chk("t7_expiry_err", {15'd0, error}, 16'd0);
        tick();
        chk("t7_done", {15'd0, done}, 16'd1);
        chk("t7_no_err", {15'd0, error}, 16'd0);
        chk("t7_disp_sum", disp_value, 16'h005A);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
